fwd_operand_reg: RTL

- Parametrised forwarding operand stage for the pipelined MIPS datapath.
- Generalises the fixed 3-way operand select into an N-source priority bypass.
- Flags load-use style hazards when the winning source has no data yet.
- Captures the selected operand into a pipeline register with stall and flush control.
- One instance per operand (rs, rt) at the D→E boundary. It replaces the hand-wired select muxes and the separate operand register.

---
 rtl/fwd_pkg.sv | 21 ++
 rtl/fwd_prio_enc.sv | 47 ++++
 rtl/fwd_operand_reg.sv | 85 ++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the operand-forwarding blocks.
package fwd_pkg;

    // Default register address width and datapath width of the MIPS core.
    localparam int DEF_AW    = 5;
    localparam int DEF_WIDTH = 32;

    // Register $0 is hard-wired to zero and never takes part in forwarding.
    localparam int REG_ZERO  = 0;

    // Selector value meaning "operand comes from the register file".
    function automatic int sel_rf(input int nsrc);
        return nsrc;
    endfunction

    // Width of a selector able to encode 0..nsrc (nsrc meaning register file).
    function automatic int sel_width(input int nsrc);
        return (nsrc < 1) ? 1 : $clog2(nsrc + 1);
    endfunction

endpackage

// File: rtl/fwd_prio_enc.sv
// Priority matcher: finds the youngest forwarding source writing the
// register being read. Index 0 is the youngest and wins over all others.
module fwd_prio_enc
    import fwd_pkg::*;
#(
    parameter int NSRC = 3,
    parameter int AW   = DEF_AW,
    parameter int SW   = sel_width(NSRC)
) (
    input  logic [AW-1:0]      rd_addr,
    input  logic [NSRC-1:0]    src_valid,
    input  logic [NSRC*AW-1:0] src_addr,
    input  logic [NSRC-1:0]    src_ready,
    output logic               match,
    output logic [SW-1:0]      winner,
    output logic               winner_ready
);

    logic [NSRC-1:0] hit;
    logic            rd_is_zero;

    assign rd_is_zero = (rd_addr == AW'(REG_ZERO));

    // Per-source address comparison; $0 reads never match anything.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit[i] = src_valid[i] && (src_addr[i*AW +: AW] == rd_addr) && !rd_is_zero;
        end
    end

    // Walk from oldest to youngest so the lowest matching index is the last
    // one written and therefore wins; only the winner's readiness is reported.
    always_comb begin
        match        = 1'b0;
        winner       = SW'(sel_rf(NSRC));
        winner_ready = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match        = 1'b1;
                winner       = SW'(i);
                winner_ready = src_ready[i];
            end
        end
    end

endmodule

// File: rtl/fwd_operand_reg.sv
// Forwarding operand stage at the D->E boundary: selects the operand from
// the youngest matching in-flight result (or the register file), flags a
// hazard when that result is not computed yet, and registers the operand
// with flush and stall control.
//
// Flow control: in_valid qualifies the decode instruction. A capture only
// happens when neither stall nor hazard is high; hazard acts as the local
// "not ready" and holds the register until the winning source is ready.
// Flush overrides both and empties the register.
module fwd_operand_reg
    import fwd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = 3,
    parameter int AW    = DEF_AW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [AW-1:0]               rd_addr,
    input  logic [WIDTH-1:0]            rf_data,
    input  logic [NSRC-1:0]             src_valid,
    input  logic [NSRC*AW-1:0]          src_addr,
    input  logic [NSRC-1:0]             src_ready,
    input  logic [NSRC*WIDTH-1:0]       src_data,
    input  logic                        stall,
    input  logic                        flush,
    output logic                        hazard,
    output logic [WIDTH-1:0]            q_data,
    output logic [$clog2(NSRC+1)-1:0]   q_sel,
    output logic                        q_valid
);

    localparam int SW = $clog2(NSRC + 1);
    localparam logic [SW-1:0] SEL_RF = SW'(sel_rf(NSRC));

    logic            match;
    logic [SW-1:0]   winner;
    logic            winner_ready;
    logic [WIDTH-1:0] sel_data;

    fwd_prio_enc #(
        .NSRC (NSRC),
        .AW   (AW),
        .SW   (SW)
    ) u_prio (
        .rd_addr      (rd_addr),
        .src_valid    (src_valid),
        .src_addr     (src_addr),
        .src_ready    (src_ready),
        .match        (match),
        .winner       (winner),
        .winner_ready (winner_ready)
    );

    // N-way data select driven by the winner index; register file otherwise.
    always_comb begin
        sel_data = rf_data;
        for (int i = 0; i < NSRC; i++) begin
            if (match && (winner == SW'(i))) begin
                sel_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign hazard = in_valid && match && !winner_ready;

    // Operand register: flush empties, stall/hazard hold, otherwise capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_sel   <= SEL_RF;
        end else if (flush) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_sel   <= SEL_RF;
        end else if (!(stall || hazard)) begin
            q_valid <= in_valid;
            q_data  <= sel_data;
            q_sel   <= winner;
        end
    end

endmodule
